// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller states, default primitive feedback masks
// and the LFSR seed guard.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_CMP,
        ST_DONE
    } bist_state_e;

    // Tap masks for a shift-left register whose new LSB is ^(reg & mask).
    function automatic logic [15:0] default_poly(input int width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
    function automatic logic [31:0] lockup_safe_seed(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift-left with XOR feedback, response
// folded in on every enabled cycle.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH))
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] resp_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clr_i) begin
            misr_d = '0;
        end else if (en_i) begin
            misr_d = {misr_q[WIDTH-2:0], ^(misr_q & POLY)} ^ resp_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig_o = misr_q;

endmodule

// File: rtl/bist_engine_param.sv
// Logic BIST controller: LFSR stimulus, MISR compaction, golden compare.
// Define BIST_SIG_DBG_EN to expose the live signature on sig_out.
module bist_engine_param
    import bist_pkg::*;
#(
    parameter int               N_IN      = 5,
    parameter int               N_OUT     = 9,
    parameter int               N_PAT     = 30,
    parameter logic [N_IN-1:0]  SEED      = N_IN'(1),
    parameter logic [N_IN-1:0]  LFSR_POLY = N_IN'(default_poly(N_IN)),
    parameter logic [N_OUT-1:0] MISR_POLY = N_OUT'(default_poly(N_OUT)),
    parameter logic [N_OUT-1:0] GOLDEN    = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bist_start,
    input  logic [N_IN-1:0]  func_in,
    output logic [N_IN-1:0]  cut_in,
    input  logic [N_OUT-1:0] cut_resp,
    output logic             bist_busy,
    output logic             bist_end,
    output logic             pass_nfail
`ifdef BIST_SIG_DBG_EN
    ,
    output logic [N_OUT-1:0] sig_out
`endif
);

    localparam int              CNT_W     = $clog2(N_PAT + 1);
    localparam logic [N_IN-1:0] SEED_INIT = N_IN'(lockup_safe_seed(32'(SEED)));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(N_PAT);

    bist_state_e      state_q, state_d;
    logic [N_IN-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             end_q, end_d;
    logic             pass_q, pass_d;
    logic             misr_clr;
    logic             misr_en;
    logic [N_OUT-1:0] misr_sig;

    bist_misr #(
        .WIDTH (N_OUT),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk_i  (clock),
        .rst_ni (reset),
        .clr_i  (misr_clr),
        .en_i   (misr_en),
        .resp_i (cut_resp),
        .sig_o  (misr_sig)
    );

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        end_d    = end_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bist_start) begin
                    state_d = ST_SEED;
                end
            end
            ST_SEED: begin
                lfsr_d   = SEED_INIT;
                cnt_d    = '0;
                end_d    = 1'b0;
                pass_d   = 1'b0;
                misr_clr = 1'b1;
                state_d  = bist_start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!bist_start) begin
                    state_d = ST_IDLE;
                    end_d   = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    // The response to the pattern on cut_in is captured on this same edge.
                    misr_en = 1'b1;
                    lfsr_d  = {lfsr_q[N_IN-2:0], ^(lfsr_q & LFSR_POLY)};
                    if (cnt_q != MAX_CNT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                pass_d  = (misr_sig == GOLDEN);
                end_d   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Only a released start re-arms the engine.
                if (!bist_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED_INIT;
            cnt_q   <= '0;
            end_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        bist_busy = (state_q == ST_SEED) || (state_q == ST_RUN) || (state_q == ST_CMP);
        cut_in    = bist_busy ? lfsr_q : func_in;
    end

    assign bist_end   = end_q;
    assign pass_nfail = pass_q;

`ifdef BIST_SIG_DBG_EN
    assign sig_out = misr_sig;
`endif

endmodule
